// File: rtl/lcd_frame_ctrl.sv
// LCD frame sequencer: panel reset/power-up command stream, then split-colour
// RGB565 frames, driven byte-by-byte through an external spi_master.
module lcd_frame_ctrl #(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 240,
    parameter int RST_CYCLES  = 100000,
    parameter int WAIT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw,
    input  logic [15:0] color_p1,
    input  logic [15:0] color_p2,
    output logic        spi_start,
    output logic [7:0]  spi_data,
    input  logic        spi_done,
    output logic        lcd_dc,
    output logic        lcd_rst_n,
    output logic        init_done,
    output logic        busy,
    output logic        frame_done
);

    localparam int DLY_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    localparam logic [DLY_W-1:0] RST_LAST  = DLY_W'(RST_CYCLES - 1);
    localparam logic [DLY_W-1:0] WAIT_LAST = DLY_W'(WAIT_CYCLES - 1);
    localparam logic [15:0]      X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0]      Y_LAST    = 16'(HEIGHT - 1);
    localparam logic [15:0]      X_HALF    = 16'(WIDTH / 2);
    localparam logic [3:0]       INIT_LAST = 4'd4;
    localparam logic [3:0]       WIN_LAST  = 4'd10;

    typedef enum logic [3:0] {
        S_RST_LO,
        S_RST_WAIT,
        S_INIT_SEND,
        S_INIT_WAIT,
        S_INIT_DLY,
        S_IDLE,
        S_WIN_SEND,
        S_WIN_WAIT,
        S_PIX_SEND,
        S_PIX_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [DLY_W-1:0] dly_cnt;
    logic [3:0]       idx;
    logic [15:0]      px_x, px_y;
    logic             px_lo;
    logic [15:0]      p1_lat, p2_lat;
    logic [7:0]       tx_byte;
    logic             tx_dc;
    logic             init_done_r, frame_done_r;

    logic [9:0]       init_ent;
    logic [8:0]       win_ent;
    logic [15:0]      px_color;
    logic [7:0]       send_byte;
    logic             send_dc;
    logic             in_wait;
    logic             frame_last;
    logic             dly_state;

    // {delay_after, dc, byte}
    function automatic logic [9:0] init_rom(input logic [3:0] i);
        case (i)
            4'd0:    return {1'b1, 1'b0, 8'h01};
            4'd1:    return {1'b1, 1'b0, 8'h11};
            4'd2:    return {1'b0, 1'b0, 8'h3A};
            4'd3:    return {1'b0, 1'b1, 8'h55};
            default: return {1'b0, 1'b0, 8'h29};
        endcase
    endfunction

    // {dc, byte}: column window, row window, then RAMWR
    function automatic logic [8:0] win_rom(input logic [3:0] i);
        case (i)
            4'd0:    return {1'b0, 8'h2A};
            4'd1:    return {1'b1, 8'h00};
            4'd2:    return {1'b1, 8'h00};
            4'd3:    return {1'b1, X_LAST[15:8]};
            4'd4:    return {1'b1, X_LAST[7:0]};
            4'd5:    return {1'b0, 8'h2B};
            4'd6:    return {1'b1, 8'h00};
            4'd7:    return {1'b1, 8'h00};
            4'd8:    return {1'b1, Y_LAST[15:8]};
            4'd9:    return {1'b1, Y_LAST[7:0]};
            default: return {1'b0, 8'h2C};
        endcase
    endfunction

    assign init_ent   = init_rom(idx);
    assign win_ent    = win_rom(idx);
    assign px_color   = (px_x < X_HALF) ? p1_lat : p2_lat;
    assign frame_last = px_lo && (px_x == X_LAST) && (px_y == Y_LAST);
    assign dly_state  = (state == S_RST_LO) || (state == S_RST_WAIT) || (state == S_INIT_DLY);

    always_comb begin
        state_nxt = state;
        send_byte = 8'h00;
        send_dc   = 1'b0;
        case (state)
            S_RST_LO:    if (dly_cnt == RST_LAST) state_nxt = S_RST_WAIT;
            S_RST_WAIT:  if (dly_cnt == WAIT_LAST) state_nxt = S_INIT_SEND;
            S_INIT_SEND: begin
                send_byte = init_ent[7:0];
                send_dc   = init_ent[8];
                state_nxt = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (spi_done) begin
                    if (init_ent[9])           state_nxt = S_INIT_DLY;
                    else if (idx == INIT_LAST) state_nxt = S_IDLE;
                    else                       state_nxt = S_INIT_SEND;
                end
            end
            S_INIT_DLY:  if (dly_cnt == WAIT_LAST) state_nxt = S_INIT_SEND;
            S_IDLE:      if (draw) state_nxt = S_WIN_SEND;
            S_WIN_SEND: begin
                send_byte = win_ent[7:0];
                send_dc   = win_ent[8];
                state_nxt = S_WIN_WAIT;
            end
            S_WIN_WAIT: begin
                if (spi_done) state_nxt = (idx == WIN_LAST) ? S_PIX_SEND : S_WIN_SEND;
            end
            S_PIX_SEND: begin
                send_byte = px_lo ? px_color[7:0] : px_color[15:8];
                send_dc   = 1'b1;
                state_nxt = S_PIX_WAIT;
            end
            S_PIX_WAIT: begin
                if (spi_done) state_nxt = frame_last ? S_IDLE : S_PIX_SEND;
            end
            default:     state_nxt = S_RST_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RST_LO;
            dly_cnt      <= '0;
            idx          <= '0;
            px_x         <= '0;
            px_y         <= '0;
            px_lo        <= 1'b0;
            init_done_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_r <= 1'b0;
            // Delay counter restarts on every state change so each wait starts from zero.
            if (state_nxt != state)
                dly_cnt <= '0;
            else if (dly_state)
                dly_cnt <= dly_cnt + DLY_W'(1);
            case (state)
                S_INIT_WAIT: begin
                    if (spi_done && !init_ent[9]) begin
                        if (idx == INIT_LAST) init_done_r <= 1'b1;
                        else                  idx <= idx + 4'd1;
                    end
                end
                S_INIT_DLY:  if (dly_cnt == WAIT_LAST) idx <= idx + 4'd1;
                S_IDLE:      if (draw) idx <= '0;
                S_WIN_WAIT: begin
                    if (spi_done) begin
                        if (idx == WIN_LAST) begin
                            idx   <= '0;
                            px_x  <= '0;
                            px_y  <= '0;
                            px_lo <= 1'b0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                S_PIX_WAIT: begin
                    if (spi_done) begin
                        px_lo <= ~px_lo;
                        if (px_lo) begin
                            if (px_x == X_LAST) begin
                                px_x <= '0;
                                if (px_y == Y_LAST) begin
                                    px_y         <= '0;
                                    frame_done_r <= 1'b1;
                                end else begin
                                    px_y <= px_y + 16'd1;
                                end
                            end else begin
                                px_x <= px_x + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte/dc held for the outstanding transfer; colours frozen at frame acceptance.
    always_ff @(posedge clk) begin
        if (spi_start) begin
            tx_byte <= send_byte;
            tx_dc   <= send_dc;
        end
        if ((state == S_IDLE) && draw) begin
            p1_lat <= color_p1;
            p2_lat <= color_p2;
        end
    end

    assign spi_start  = (state == S_INIT_SEND) || (state == S_WIN_SEND) || (state == S_PIX_SEND);
    assign in_wait    = (state == S_INIT_WAIT) || (state == S_WIN_WAIT) || (state == S_PIX_WAIT);
    assign spi_data   = in_wait ? tx_byte : send_byte;
    assign lcd_dc     = in_wait ? tx_dc : send_dc;
    assign lcd_rst_n  = (state != S_RST_LO);
    assign busy       = (state != S_IDLE);
    assign init_done  = init_done_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/lcd_frame_ctrl.md
Name: lcd_frame_ctrl

Overview:
- Sequencer placed above spi_master on the LCD path.
- Runs the panel hardware-reset and power-up command sequence, then draws full frames on request.
- Each frame is split vertically: left half in colour P1, right half in colour P2, both RGB565.
- Generates every byte, the D/C flag and the start/done handshake for spi_master. It is the only master of that SPI instance.

Parameters:
- WIDTH, 240, panel columns; even, 2..65535.
- HEIGHT, 240, panel rows; 1..65535.
- RST_CYCLES, 100000, clk cycles lcd_rst_n is held low after reset.
- WAIT_CYCLES, 1200000, clk cycles of idle after lcd_rst_n release, after SWRESET and after SLPOUT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- draw  in  1  frame request; sampled only in IDLE.
- color_p1  in  16  RGB565 colour for the left half (x < WIDTH/2).
- color_p2  in  16  RGB565 colour for the right half (x >= WIDTH/2).
- spi_start  out  1  one-cycle pulse to spi_master, qualifies spi_data.
- spi_data  out  8  byte to transmit; held stable until spi_done.
- spi_done  in  1  completion pulse from spi_master.
- lcd_dc  out  1  0 = command byte, 1 = data byte; stable from spi_start until spi_done.
- lcd_rst_n  out  1  panel hardware reset, active low.
- init_done  out  1  high once the init sequence completes; sticky until rst.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel byte's spi_done.

Behaviour:
- Reset values (rst high at an edge): spi_start=0, spi_data=0x00, lcd_dc=0, lcd_rst_n=0, init_done=0, busy=1, frame_done=0. State becomes RST_LO and all counters clear.
- rst mid-transfer: the current transfer is abandoned and no further spi_start is issued. The sequence restarts from RST_LO.
- Byte transfer, shared by all send states:
  - SEND: spi_start=1 for exactly one cycle. spi_data and lcd_dc are set in the same cycle.
  - WAIT: hold until spi_done=1, then advance on the next edge.
  - Never more than one byte outstanding.
  - spi_done arriving outside WAIT is ignored.
- RST_LO: lcd_rst_n=0 for RST_CYCLES cycles, then set lcd_rst_n=1.
- RST_WAIT: WAIT_CYCLES idle cycles.
- INIT: walks a fixed ROM of entries {dc, byte, delay_after}:
  - (0,0x01,yes) SWRESET
  - (0,0x11,yes) SLPOUT
  - (0,0x3A,no) COLMOD
  - (1,0x55,no) 16-bit pixel format
  - (0,0x29,no) DISPON
  - A "yes" entry inserts WAIT_CYCLES idle cycles after its spi_done.
- After the last INIT entry: init_done=1, busy=0, state IDLE.
- IDLE, draw=1: latch color_p1 and color_p2 into internal registers, set busy=1 on the next edge, go to WIN.
  - Input colour changes after acceptance do not affect the frame in progress.
  - draw while busy is dropped, not queued. draw held high redraws back-to-back.
- WIN: 11 bytes, in order:
  - (0,0x2A); (1,0x00); (1,0x00); (1,(WIDTH-1)[15:8]); (1,(WIDTH-1)[7:0])
  - (0,0x2B); (1,0x00); (1,0x00); (1,(HEIGHT-1)[15:8]); (1,(HEIGHT-1)[7:0])
  - (0,0x2C)
- PIX: pixels in raster order, x fastest.
  - Per pixel: byte colour[15:8] then colour[7:0], dc=1.
  - colour = P1 if x < WIDTH/2, else P2.
  - x counter wraps from WIDTH-1 to 0 and increments y.
  - Total pixel bytes = 2*WIDTH*HEIGHT; use 16-bit x/y counters.
- After the final pixel byte's spi_done: frame_done=1 for one cycle, busy=0, state IDLE. The next draw may be accepted in the cycle after frame_done.
- Delay counters are sized to hold max(RST_CYCLES, WAIT_CYCLES). A count of N yields exactly N cycles.

Test Plan (bench: WIDTH=4, HEIGHT=2, RST_CYCLES=8, WAIT_CYCLES=5; spi_master model asserts spi_done 3 cycles after spi_start):
- Reset release -> lcd_rst_n low exactly 8 cycles, then high; first spi_start after 5 further cycles with byte 0x01 and dc=0. Check all reset values during rst.
- Init -> byte/dc stream 01/0, 11/0, 3A/0, 55/1, 29/0; a 5-cycle gap after the spi_done of 01 and of 11; then init_done=1, busy=0.
- draw pulse with p1=F800, p2=001F -> 27 transfers: 2A,00,00,00,03,2B,00,00,00,01,2C, then per row F8,00,F8,00,00,1F,00,1F (two rows); one frame_done pulse; busy low after.
- Change colours to 07E0/001F mid-frame -> current frame unchanged. The next draw emits 07,E0,07,E0,00,1F,00,1F per row.
- draw asserted while busy -> ignored, exactly one frame_done. spi_done injected in IDLE -> no state change. No spi_start is issued while a byte is outstanding.
- rst pulsed during a pixel byte -> spi_start stays low, lcd_rst_n=0 and init_done=0 next cycle, full init replays.
